dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder that sits on the target side of the pipeline's memory-stage data interface.
- Accepts one load/store request at a time from the M stage and serves it after a fixed latency.
- Raises a stall toward the hazard unit while the request is outstanding.
- Replaces the single-cycle data memory, so the pipeline can be exercised against realistic memory timing.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the storage array; must be a power of two.
- LATENCY, 2: clock edges from request acceptance to the response cycle; legal range 1..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0. Must be aligned to DEPTH_WORDS*4.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  M stage holds a load or store request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address (ALUResultM).
- req_wdata  input  32  store data (WriteDataM).
- req_ready  output  1  responder can accept a request this cycle.
- resp_valid  output  1  one-cycle pulse: request completed.
- resp_rdata  output  32  load data, valid when resp_valid=1.
- resp_err  output  1  qualifies resp_valid: address out of range or misaligned.
- stall  output  1  request outstanding; hazard unit holds F/D/E/M.

Behaviour:
- Reset is asynchronous and active-high on rst; one clock, clk.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, stall=0, latency counter=0.
- The storage array is not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. If req_valid=1 at a rising edge, the request is accepted:
    - req_write, req_addr and req_wdata are captured into internal registers.
    - counter loads LATENCY-1.
    - Next state is WAIT if LATENCY>1, otherwise RESP.
  - WAIT: req_ready=0. The counter decrements each edge. On the edge where counter==1, next state is RESP.
  - RESP: resp_valid=1 for exactly this cycle, req_ready=0. Next state is IDLE unconditionally.
- Latency: a request accepted at edge T produces resp_valid high during the cycle after edge T+LATENCY-1.
- Throughput: the RESP cycle cannot accept a request, so back-to-back requests complete every LATENCY+1 cycles.
- Array access happens on the edge entering RESP, using the captured request:
  - Store: writes the array.
  - Load: registers the array word into resp_rdata.
  - resp_rdata holds its value until the next load completes. Stores leave it unchanged.
- Index = (captured_addr - BASE_ADDR) >> 2, using the low log2(DEPTH_WORDS) bits.
- Error condition: captured_addr[1:0] != 0, or captured_addr outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS).
  - resp_err=1 during RESP.
  - A store is dropped.
  - A load returns resp_rdata=0.
- stall = (req_valid & state==IDLE) | (state==WAIT). stall is combinational and is 0 in RESP, so the pipeline advances on the edge ending RESP.
- Request inputs changing or req_valid dropping during WAIT are ignored. The captured transaction always completes; there is no abort.
- rst asserted in WAIT or RESP: return to IDLE immediately; a pending store is discarded and never written.
- A load following a store to the same address observes the stored value, because the store is complete before the load is accepted.

Optional Feature:
- Macro: DMEM_RESPONDER_WSTRB_EN.
- Defined:
  - Adds input port req_wstrb[3:0], captured with the request.
  - Stores update only bytes whose strobe bit is 1.
  - req_wstrb==0 on a store completes normally with no array change.
  - The misalignment check is relaxed for stores to the following legal halfword/byte patterns:
    - addr[1:0]==2'b10 with strobe 4'b1100.
    - Any addr[1:0] with a single strobe bit matching that byte lane.
- Not defined: no req_wstrb port; every store writes the full word; any addr[1:0]!=0 is an error.

Test Plan:
- LATENCY=2: store 32'hDEADBEEF to 0x10 at edge T -> stall=1 in cycles T-1..T+1; resp_valid=1 in cycle after T+1; resp_err=0. Then load 0x10 -> resp_rdata=32'hDEADBEEF.
- LATENCY=1: req_valid held high across two loads -> accepted at edges T and T+2; resp_valid pulses at cycles T+1 and T+3; req_ready=0 in response cycles.
- Load from 0x1000 with DEPTH_WORDS=1024 (out of range) -> resp_err=1, resp_rdata=0. Store to 0x6 -> resp_err=1, array word 1 unchanged.
- Store 32'h12345678 to 0x20, rst asserted during WAIT -> outputs at reset values same cycle; later load of 0x20 returns the old contents, not 32'h12345678.
- During WAIT, change req_addr/req_wdata and drop req_valid -> response reflects the originally captured store; exactly one resp_valid.
- With DMEM_RESPONDER_WSTRB_EN: word 32'hAABBCCDD at 0x40, then store 32'h00001100 with strobe 4'b0010 -> load 0x40 returns 32'hAABB11DD.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder with stall toward the hazard unit.
// Optional byte-strobe stores when DMEM_RESPONDER_WSTRB_EN is defined.
module dmem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
`ifdef DMEM_RESPONDER_WSTRB_EN
   input  logic [3:0]  req_wstrb,
`endif
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        stall
);
   localparam int AW = $clog2(DEPTH_WORDS);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state, state_nx;
   logic [3:0] cnt;
   logic cap_write;
   logic [31:0] cap_addr, cap_wdata;
   logic [31:0] mem [DEPTH_WORDS];
   logic a_write, a_err, a_misal, enter_resp;
   logic [31:0] a_addr, a_wdata, a_off;
   logic [3:0] a_strb;
   logic [AW-1:0] a_idx;
`ifdef DMEM_RESPONDER_WSTRB_EN
   logic [3:0] cap_strb;
`endif
   // With LATENCY==1 the array is accessed on the accepting edge, so operands bypass the capture registers.
   always_comb begin
      a_write = state == IDLE ? req_write : cap_write;
      a_addr  = state == IDLE ? req_addr : cap_addr;
      a_wdata = state == IDLE ? req_wdata : cap_wdata;
`ifdef DMEM_RESPONDER_WSTRB_EN
      a_strb  = state == IDLE ? req_wstrb : cap_strb;
      a_misal = a_addr[1:0] != 2'b00 && !(a_write && ((a_addr[1:0] == 2'b10 && a_strb == 4'b1100) ||
                a_strb == (4'b0001 << a_addr[1:0])));
`else
      a_strb  = 4'hF;
      a_misal = a_addr[1:0] != 2'b00;
`endif
      a_off   = a_addr - BASE_ADDR;
      a_idx   = a_off[AW+1:2];
      a_err   = a_misal || (a_off >> (AW + 2)) != 32'd0;
   end
   always_comb begin
      state_nx   = state == IDLE ? (req_valid ? (LATENCY > 1 ? WAIT : RESP) : IDLE) :
                   state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
      enter_resp = state != RESP && state_nx == RESP;
      req_ready  = state == IDLE;
      resp_valid = state == RESP;
      stall      = (req_valid && state == IDLE) || state == WAIT;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
         cap_write  <= 1'b0;
         cap_addr   <= 32'd0;
         cap_wdata  <= 32'd0;
`ifdef DMEM_RESPONDER_WSTRB_EN
         cap_strb   <= 4'd0;
`endif
      end else begin
         state    <= state_nx;
         resp_err <= enter_resp && a_err;
         if (state == IDLE && req_valid) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
`ifdef DMEM_RESPONDER_WSTRB_EN
            cap_strb  <= req_wstrb;
`endif
            cnt       <= 4'(LATENCY - 1);
         end else if (state == WAIT) cnt <= cnt - 4'd1;
         if (enter_resp && !a_write) resp_rdata <= a_err ? 32'd0 : mem[a_idx];
      end
   end
   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (!rst && enter_resp && a_write && !a_err)
         for (int b = 0; b < 4; b++)
            if (a_strb[b]) mem[a_idx][8*b +: 8] <= a_wdata[8*b +: 8];
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench; LATENCY=2 instance for function, LATENCY=1 instance for timing.
module tb_dmem_responder;
   logic clk = 0, rst = 1;
   always #5 clk = ~clk;
   logic v, w, ready, rv, err, stall;
   logic [31:0] addr, wdata, rd;
   logic v1, w1, ready1, rv1, err1, stall1;
   logic [31:0] a1, d1, rd1;
`ifdef DMEM_RESPONDER_WSTRB_EN
   logic [3:0] strb;
`endif
   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst(rst), .req_valid(v), .req_write(w), .req_addr(addr), .req_wdata(wdata),
`ifdef DMEM_RESPONDER_WSTRB_EN
      .req_wstrb(strb),
`endif
      .req_ready(ready), .resp_valid(rv), .resp_rdata(rd), .resp_err(err), .stall(stall));
   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0)) dut1 (
      .clk(clk), .rst(rst), .req_valid(v1), .req_write(w1), .req_addr(a1), .req_wdata(d1),
`ifdef DMEM_RESPONDER_WSTRB_EN
      .req_wstrb(4'hF),
`endif
      .req_ready(ready1), .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1), .stall(stall1));
   typedef struct {logic err; logic [31:0] rdata;} exp_t;
   exp_t q[$];
   int checks = 0, failures = 0, resp_count = 0, n0;
   logic [31:0] last_rd = 32'd0;
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (!rst && rv === 1'b1) begin
         resp_count++;
         if (q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
         else begin
            e = q.pop_front();
            chk("resp_err", {31'd0, err}, {31'd0, e.err});
            chk("resp_rdata", rd, e.rdata);
         end
      end
   end
   task automatic wait_idle();
      int n = 0;
      while (ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) chk("idle_timeout", 32'd0, 32'd1);
   endtask
   task automatic req(input logic wr, input logic [31:0] ad, input logic [31:0] dat,
                      input logic e_err, input logic [31:0] e_rd);
      v = 1; w = wr; addr = ad; wdata = dat;
      if (!wr) last_rd = e_err ? 32'd0 : e_rd;
      q.push_back('{err: e_err, rdata: last_rd});
      @(posedge clk); #1;
      v = 0;
      wait_idle();
   endtask
   initial begin
      v = 0; w = 0; addr = 0; wdata = 0; v1 = 0; w1 = 0; a1 = 0; d1 = 0;
`ifdef DMEM_RESPONDER_WSTRB_EN
      strb = 4'hF;
`endif
      @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, rv}, 32'd0);
      chk("rst_rdata", rd, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_ready1", {31'd0, ready1}, 32'd1);
      rst = 0;
      @(posedge clk); #1;
      // store with stall/ready timing
      v = 1; w = 1; addr = 32'h10; wdata = 32'hDEADBEEF;
      q.push_back('{err: 1'b0, rdata: last_rd});
      @(negedge clk);
      chk("pre_stall", {31'd0, stall}, 32'd1);
      chk("pre_ready", {31'd0, ready}, 32'd1);
      @(posedge clk); #1;
      v = 0;
      @(negedge clk);
      chk("wait_stall", {31'd0, stall}, 32'd1);
      chk("wait_ready", {31'd0, ready}, 32'd0);
      chk("wait_rv", {31'd0, rv}, 32'd0);
      @(negedge clk);
      chk("resp_rv", {31'd0, rv}, 32'd1);
      chk("resp_stall", {31'd0, stall}, 32'd0);
      chk("resp_ready", {31'd0, ready}, 32'd0);
      @(posedge clk); #1;
      chk("back_idle", {31'd0, ready}, 32'd1);
      req(0, 32'h10, 0, 0, 32'hDEADBEEF);
      // range boundaries
      req(1, 32'hFFC, 32'h01020304, 0, 0);
      req(0, 32'hFFC, 0, 0, 32'h01020304);
      req(0, 32'h1000, 0, 1, 0);
      // misaligned store is dropped, misaligned load errors
      req(1, 32'h4, 32'h11112222, 0, 0);
      req(1, 32'h6, 32'h99999999, 1, 0);
      req(0, 32'h4, 0, 0, 32'h11112222);
      req(0, 32'h5, 0, 1, 0);
      // reset during WAIT discards the pending store
      req(1, 32'h20, 32'h0BADF00D, 0, 0);
      req(0, 32'h20, 0, 0, 32'h0BADF00D);
      v = 1; w = 1; addr = 32'h20; wdata = 32'h12345678;
      @(posedge clk); #1;
      v = 0;
      #1 rst = 1;
      #1;
      chk("arst_ready", {31'd0, ready}, 32'd1);
      chk("arst_stall", {31'd0, stall}, 32'd0);
      chk("arst_rv", {31'd0, rv}, 32'd0);
      chk("arst_rdata", rd, 32'd0);
      last_rd = 32'd0;
      @(negedge clk); rst = 0;
      @(posedge clk); #1;
      req(0, 32'h20, 0, 0, 32'h0BADF00D);
      // inputs changing during WAIT are ignored
      n0 = resp_count;
      v = 1; w = 1; addr = 32'h30; wdata = 32'hCAFEF00D;
      q.push_back('{err: 1'b0, rdata: last_rd});
      @(posedge clk); #1;
      v = 0; w = 0; addr = 32'h34; wdata = 32'hFFFFFFFF;
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      chk("one_resp", 32'(resp_count - n0), 32'd1);
      req(0, 32'h30, 0, 0, 32'hCAFEF00D);
`ifdef DMEM_RESPONDER_WSTRB_EN
      req(1, 32'h40, 32'hAABBCCDD, 0, 0);
      strb = 4'b0010;
      req(1, 32'h40, 32'h00001100, 0, 0);
      strb = 4'b0000;
      req(1, 32'h40, 32'hFFFFFFFF, 0, 0);
      strb = 4'b1000;
      req(1, 32'h43, 32'h77000000, 0, 0);
      strb = 4'hF;
      req(0, 32'h40, 0, 0, 32'h77BB11DD);
`endif
      // LATENCY=1 instance: data path through the bypass
      v1 = 1; w1 = 1; a1 = 32'h8; d1 = 32'h5A5A1234;
      @(posedge clk); #1;
      v1 = 0;
      @(negedge clk);
      chk("l1_st_rv", {31'd0, rv1}, 32'd1);
      chk("l1_st_err", {31'd0, err1}, 32'd0);
      @(posedge clk); #1;
      v1 = 1; w1 = 0;
      @(negedge clk);
      chk("l1_pre_stall", {31'd0, stall1}, 32'd1);
      chk("l1_pre_ready", {31'd0, ready1}, 32'd1);
      @(negedge clk);
      chk("l1_rv_a", {31'd0, rv1}, 32'd1);
      chk("l1_ready_a", {31'd0, ready1}, 32'd0);
      chk("l1_stall_a", {31'd0, stall1}, 32'd0);
      chk("l1_rdata_a", rd1, 32'h5A5A1234);
      @(negedge clk);
      chk("l1_gap_rv", {31'd0, rv1}, 32'd0);
      chk("l1_gap_ready", {31'd0, ready1}, 32'd1);
      @(negedge clk);
      chk("l1_rv_b", {31'd0, rv1}, 32'd1);
      chk("l1_ready_b", {31'd0, ready1}, 32'd0);
      @(posedge clk); #1;
      v1 = 0;
      @(negedge clk);
      chk("l1_end_rv", {31'd0, rv1}, 32'd0);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
